smag_mul_seq: RTL

- Sequential sign-magnitude multiplier controller for the accumulator computer.
- Time-shares the existing combinational sign-magnitude adder, which is instantiated outside this block. The block drives the adder operands and reads back its sum.
- Computes a 15x15-bit magnitude product by shift-and-add. The result is truncated to 16-bit sign-magnitude, with an overflow flag.
- Sits between the control unit (start/done handshake) and the shared adder.

---
 rtl/smag_mul_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/smag_mul_seq.sv
// rtl/smag_mul_seq.sv - sequential sign-magnitude shift-and-add multiplier driving a shared magnitude adder
// Optional SMUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain above the current one.
module smag_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    localparam int MW   = WIDTH - 1;
    localparam int ITER = WIDTH - 1;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    logic [MW-1:0]   r_mag_a;
    logic [MW-1:0]   r_mag_b;
    logic            r_sgn;
    logic [MW-1:0]   r_acc;
    logic            r_ovf_int;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic [WIDTH-1:0] r_result;
    logic            r_ovf;

    logic [2*MW-1:0] w_shift;
    logic            w_bit;
    logic            w_wrap;
    logic            w_lost;
    logic            w_last;
    logic            w_unused_sign;

    assign w_shift = {{MW{1'b0}}, r_mag_a} << r_cnt;
    assign w_bit   = r_mag_b[r_cnt];
    // A 15-bit sum smaller than the accumulator means the adder carried out of the magnitude.
    assign w_wrap  = add_c[MW-1:0] < r_acc;
    assign w_lost  = |w_shift[2*MW-1:MW];
    assign w_unused_sign = add_c[WIDTH-1];

`ifdef SMUL_EARLY_EXIT_EN
    assign w_last = (r_cnt == CW'(ITER - 1)) || ((r_mag_b >> (r_cnt + 1'b1)) == '0);
`else
    assign w_last = (r_cnt == CW'(ITER - 1));
`endif

    // Adder operands always carry a zero sign so the shared adder acts as a magnitude adder.
    assign add_a  = (r_state == S_CALC) ? {1'b0, r_acc} : '0;
    assign add_b  = (r_state == S_CALC) ? {1'b0, w_shift[MW-1:0]} : '0;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign ovf    = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_sgn     <= 1'b0;
            r_acc     <= '0;
            r_ovf_int <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mag_a   <= op_a[MW-1:0];
                        r_mag_b   <= op_b[MW-1:0];
                        r_sgn     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_acc     <= '0;
                        r_ovf_int <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_bit) begin
                        r_acc <= add_c[MW-1:0];
                        if (w_wrap || w_lost) begin
                            r_ovf_int <= 1'b1;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A zero magnitude is reported as +0 regardless of the operand signs.
                    r_result <= (r_acc == '0) ? '0 : {r_sgn, r_acc};
                    r_ovf    <= r_ovf_int;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
